// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Pipeline-side partner of the hazard unit. Feeds the unit its decode
//   fields and an EX/MEM/WB shadow of destination and memory-control bits,
//   turns the unit's verdicts into PC / latch enables and flushes, and
//   sequences the HALT drain.
// Ports
//   CLK, nRST                      clock, async active-low reset
//   ihit, dhit                     instruction / data memory ready
//   id_*                           decode-stage fields and control bits
//   haz_hazard/branch/jump         hazard-unit verdicts
//   rsel1..dhit_o, instrOp..       hazard-unit inputs (pass-through + shadows)
//   pc_en .. memwb_en              latch controls, combinational this cycle
//   halt                           sticky, set once HALT retires
//   stall_cnt                      saturating count of cycles with pc_en=0
module pipeline_ctrl #(
  parameter logic [5:0] HALT_OP = 6'b111111,
  parameter int         CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_wsel,
  input  logic             id_regWEN,
  input  logic             id_dmemREN,
  input  logic             id_dmemWEN,
  input  logic             id_equal,
  input  logic [5:0]       id_op,
  input  logic [5:0]       id_funct,
  input  logic             haz_hazard,
  input  logic             haz_branch,
  input  logic             haz_jump,
  output logic [4:0]       rsel1,
  output logic [4:0]       rsel2,
  output logic [4:0]       ex_writeReg,
  output logic [4:0]       mem_writeReg,
  output logic             ex_regWEN,
  output logic             mem_regWEN,
  output logic             ex_dmemREN,
  output logic             equal,
  output logic             dhit_o,
  output logic [5:0]       instrOp,
  output logic [5:0]       mem_instrOp,
  output logic [5:0]       instrFunc,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_clr_mem,
  output logic             memwb_en,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic [4:0] wsel;
    logic       regwen;
    logic       dmemren;
    logic       dmemwen;
    logic [5:0] op;
  } stg_t;

  state_t state, state_nxt;
  stg_t   id_s, ex_s, mem_s;
  logic   wb_halt;
  logic   mem_acc, stall_mem, adv, id_halt;

  // pass-through to the hazard unit
  assign rsel1     = id_rs;
  assign rsel2     = id_rt;
  assign instrOp   = id_op;
  assign instrFunc = id_funct;
  assign equal     = id_equal;
  assign dhit_o    = dhit;

  assign ex_writeReg  = ex_s.wsel;
  assign ex_regWEN    = ex_s.regwen;
  assign ex_dmemREN   = ex_s.dmemren;
  assign mem_writeReg = mem_s.wsel;
  assign mem_regWEN   = mem_s.regwen;
  assign mem_instrOp  = mem_s.op;

  assign id_s = '{wsel: id_wsel, regwen: id_regWEN, dmemren: id_dmemREN,
                  dmemwen: id_dmemWEN, op: id_op};

  assign mem_acc   = mem_s.dmemren | mem_s.dmemwen;
  assign stall_mem = mem_acc & ~dhit;
  // once draining, IF is dead so the pipe no longer waits on ihit
  assign adv       = ~stall_mem & (ihit | (state == DRAIN));
  assign id_halt   = (id_op == HALT_OP);

  // state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (adv & ~haz_hazard & id_halt) state_nxt = DRAIN;
      DRAIN:   if (wb_halt)                     state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  // outputs; held low while reset is asserted
  always_comb begin
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    ifid_flush    = 1'b0;
    idex_en       = 1'b0;
    idex_flush    = 1'b0;
    exmem_en      = 1'b0;
    exmem_clr_mem = 1'b0;
    memwb_en      = 1'b0;
    halt          = 1'b0;
    if (nRST) begin
      case (state)
        RUN: begin
          pc_en         = adv & ~haz_hazard & ~id_halt;
          ifid_en       = adv & ~haz_hazard;
          // a stalled branch is left in ID and re-resolved next cycle
          ifid_flush    = adv & ~haz_hazard & (haz_branch | haz_jump | id_halt);
          idex_en       = adv;
          exmem_en      = adv;
          memwb_en      = adv;
          idex_flush    = adv & haz_hazard;
          exmem_clr_mem = mem_acc & dhit & ~adv;
        end
        DRAIN: begin
          ifid_flush    = adv;
          idex_en       = adv;
          exmem_en      = adv;
          memwb_en      = adv;
          idex_flush    = adv;
          exmem_clr_mem = mem_acc & dhit & ~adv;
        end
        HALTED:  halt = 1'b1;
        default: ;
      endcase
    end
  end

  // stage shadows advance with the real latches (memwb_en is adv outside HALTED)
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_s    <= '0;
      mem_s   <= '0;
      wb_halt <= 1'b0;
    end else if (memwb_en) begin
      ex_s    <= idex_flush ? '0 : id_s;
      mem_s   <= ex_s;
      wb_halt <= (mem_s.op == HALT_OP);
    end else if (exmem_clr_mem) begin
      // access finished while IF is still waiting: don't replay it
      mem_s.dmemren <= 1'b0;
      mem_s.dmemwen <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stall_cnt <= '0;
    else if ((state != HALTED) && !pc_en && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (CNT_W=4 so saturation is reachable).
module tb_pipeline_ctrl;
  logic       CLK = 1'b0, nRST;
  logic       ihit, dhit;
  logic [4:0] id_rs, id_rt, id_wsel;
  logic       id_regWEN, id_dmemREN, id_dmemWEN, id_equal;
  logic [5:0] id_op, id_funct;
  logic       haz_hazard, haz_branch, haz_jump;
  logic [4:0] rsel1, rsel2, ex_writeReg, mem_writeReg;
  logic       ex_regWEN, mem_regWEN, ex_dmemREN, equal, dhit_o;
  logic [5:0] instrOp, mem_instrOp, instrFunc;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic       exmem_en, exmem_clr_mem, memwb_en, halt;
  logic [3:0] stall_cnt;

  int ntests = 0;
  int nfail  = 0;

  pipeline_ctrl #(.HALT_OP(6'h3F), .CNT_W(4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel),
    .id_regWEN(id_regWEN), .id_dmemREN(id_dmemREN), .id_dmemWEN(id_dmemWEN),
    .id_equal(id_equal), .id_op(id_op), .id_funct(id_funct),
    .haz_hazard(haz_hazard), .haz_branch(haz_branch), .haz_jump(haz_jump),
    .rsel1(rsel1), .rsel2(rsel2), .ex_writeReg(ex_writeReg),
    .mem_writeReg(mem_writeReg), .ex_regWEN(ex_regWEN), .mem_regWEN(mem_regWEN),
    .ex_dmemREN(ex_dmemREN), .equal(equal), .dhit_o(dhit_o),
    .instrOp(instrOp), .mem_instrOp(mem_instrOp), .instrFunc(instrFunc),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_clr_mem(exmem_clr_mem), .memwb_en(memwb_en), .halt(halt),
    .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic nop();
    id_rs = 0; id_rt = 0; id_wsel = 0;
    id_regWEN = 0; id_dmemREN = 0; id_dmemWEN = 0; id_equal = 0;
    id_op = 0; id_funct = 0;
    haz_hazard = 0; haz_branch = 0; haz_jump = 0;
  endtask

  task automatic pulse_reset();
    nRST = 1'b0;
    #1;
    chk("rst_halt", halt, 0);
    chk("rst_cnt", stall_cnt, 0);
    nRST = 1'b1;
    #1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1; dhit = 1;
    nop();
    id_rs = 5'd3; id_wsel = 5'd7; id_regWEN = 1;
    #1;
    // reset state
    chk("rst_en", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                   exmem_en, exmem_clr_mem, memwb_en, halt}, 0);
    chk("rst_cnt0", stall_cnt, 0);
    chk("rst_shadow", {ex_writeReg, mem_writeReg, mem_instrOp}, 0);
    chk("pass_rsel1", rsel1, 3);
    tick(); tick();
    chk("rst_hold", {pc_en, stall_cnt, ex_writeReg}, 0);
    nop();
    nRST = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("nop_pc_en", pc_en, 1);
      tick();
    end
    chk("nop_cnt", stall_cnt, 0);

    // load-use: lw $5 then add $6,$5,$5 with one hazard cycle
    id_rs = 1; id_wsel = 5; id_regWEN = 1; id_dmemREN = 1; id_op = 6'h23;
    #1;
    chk("lw_pc_en", pc_en, 1);
    tick();
    chk("lw_ex", {ex_writeReg, ex_regWEN, ex_dmemREN}, {5'd5, 1'b1, 1'b1});
    nop();
    id_rs = 5; id_rt = 5; id_wsel = 6; id_regWEN = 1; id_funct = 6'h20;
    haz_hazard = 1;
    #1;
    chk("lu_ctl", {pc_en, ifid_en, idex_flush, idex_en}, 4'b0011);
    tick();
    chk("lu_bubble", {ex_writeReg, ex_regWEN}, 0);
    chk("lu_mem", {mem_writeReg, mem_regWEN}, {5'd5, 1'b1});
    chk("lu_cnt", stall_cnt, 1);
    haz_hazard = 0;
    #1;
    chk("lu_resume", pc_en, 1);
    tick();
    chk("lu_ex_add", ex_writeReg, 6);
    chk("lu_mem_bub", mem_writeReg, 0);

    // branch / jump flush, hazard priority
    nop();
    id_op = 6'h04; id_equal = 1; id_funct = 6'h11; haz_branch = 1;
    #1;
    chk("br_pass", {instrOp, instrFunc, equal, dhit_o}, {6'h04, 6'h11, 1'b1, 1'b1});
    chk("br_flush", {ifid_flush, pc_en}, 2'b11);
    haz_hazard = 1;
    #1;
    chk("br_haz", {ifid_flush, pc_en, idex_flush}, 3'b001);
    haz_hazard = 0; haz_branch = 0; haz_jump = 1; id_op = 6'h02;
    #1;
    chk("jmp_flush", {ifid_flush, pc_en}, 2'b11);
    nop();
    tick();
    chk("br_cnt", stall_cnt, 1);

    // data stall: sw into MEM, dhit low 3 cycles
    id_dmemWEN = 1; id_op = 6'h2B; id_rs = 2; id_rt = 4;
    tick();
    nop();
    tick();
    dhit = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ds_frozen", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, exmem_clr_mem}, 0);
      tick();
    end
    chk("ds_cnt3", stall_cnt, 4);
    dhit = 1; ihit = 0;
    #1;
    chk("ds_clr", {exmem_clr_mem, pc_en, memwb_en}, 3'b100);
    tick();
    chk("ds_cnt4", stall_cnt, 5);
    // access cleared: dhit low no longer stalls, no second clear
    dhit = 0; ihit = 1;
    #1;
    chk("ds_cleared", {pc_en, exmem_clr_mem}, 2'b10);
    tick();
    dhit = 1;
    tick();
    chk("ds_cnt_end", stall_cnt, 5);

    // HALT drain
    id_op = 6'h3F;
    #1;
    chk("h_id", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b0110);
    tick();                                   // edge 1 -> DRAIN
    nop();
    ihit = 0;                                 // drain must not need ihit
    #1;
    chk("h_drain", {pc_en, ifid_en, ifid_flush, idex_flush, memwb_en, halt}, 6'b001110);
    chk("h_ex_op", ex_writeReg, 0);
    tick();                                   // edge 2
    chk("h_mem_op", mem_instrOp, 6'h3F);
    chk("h_e2_halt", halt, 0);
    tick();                                   // edge 3
    chk("h_e3_halt", halt, 0);
    ihit = 1;
    tick();                                   // edge 4 -> HALTED
    chk("h_halt", halt, 1);
    for (int i = 0; i < 20; i++) begin
      chk("h_sticky", {halt, pc_en, ifid_en, idex_en, memwb_en, ifid_flush}, 6'b100000);
      tick();
    end
    chk("h_cnt", stall_cnt, 9);

    // reset mid-DRAIN
    pulse_reset();
    id_op = 6'h3F;
    tick();                                   // -> DRAIN
    nop();
    tick();
    chk("md_mem_op", mem_instrOp, 6'h3F);
    nRST = 1'b0;
    #1;
    chk("md_rst", {halt, pc_en, mem_instrOp, stall_cnt}, 0);
    nRST = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("md_run", {halt, pc_en}, 2'b01);
      tick();
    end

    // saturation with CNT_W=4
    pulse_reset();
    ihit = 0;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", stall_cnt, 4'hE);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_20", stall_cnt, 4'hF);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
